// File: rtl/mc10k_pkg.sv
// Shared types for the 10136-style counter chain: slice select encoding and
// sequencer states.
package mc10k_pkg;

   // Values match the {sel2,sel1} pins of the counter slices.
   typedef enum logic [1:0] {
      LOAD = 2'b00,
      DEC  = 2'b01,
      INC  = 2'b10,
      HOLD = 2'b11
   } tCounterMode;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RUN  = 2'b10,
      ST_DONE = 2'b11
   } tSeqState;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 of req/gnt is requester A, bit 1 is B.
// The priority flips away from the most recent winner on advance.
module rr_arb2 (
   input  logic       clk,
   input  logic       nReset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic prio_q, prio_d;   // 0: A preferred, 1: B preferred
   logic last_q, last_d;   // index of the most recent winner

   always_comb begin
      gnt    = req;
      last_d = last_q;
      prio_d = prio_q;
      if (req == 2'b11) begin
         gnt = prio_q ? 2'b10 : 2'b01;
      end
      if (gnt != 2'b00) begin
         last_d = gnt[1];
      end
      if (advance) begin
         prio_d = ~last_q;
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         prio_q <= 1'b0;
         last_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/cnt_seq.sv
// Sequencer for a cascaded 4-bit counter chain: grants the chain to A or B,
// loads the start value, steps to terminal count and signals completion.
module cnt_seq
   import mc10k_pkg::*;
#(
   parameter  int unsigned NSLICES = 3,
   localparam int unsigned W       = 4 * NSLICES
) (
   input  logic         clk,
   input  logic         nReset,
   input  logic         reqA,
   input  logic         reqB,
   input  logic [W-1:0] valA,
   input  logic [W-1:0] valB,
   input  logic         upA,
   input  logic         upB,
   output logic         gntA,
   output logic         gntB,
   output logic         doneA,
   output logic         doneB,
   input  logic         stall,
   input  logic         abort,
   output logic         busy,
   output logic         sel2,
   output logic         sel1,
   output logic         nCryIn,
   output logic [W-1:0] d,
   input  logic [W-1:0] q,
   input  logic         nCryOut,
   output logic         chainErr
);

   tSeqState     state_q, state_d;
   logic         owner_q, owner_d;   // 0: A, 1: B
   logic [W-1:0] val_q, val_d;
   logic         up_q, up_d;
   logic [1:0]   done_q, done_d;
   logic         busy_q, busy_d;
   logic         err_q, err_d;

   tCounterMode  mode;
   logic         ncry_in;
   logic         advance;
   logic         terminal;
   logic [1:0]   req_idle;
   logic [1:0]   gnt;

   assign req_idle = {reqB, reqA} & {2{state_q == ST_IDLE}};

   rr_arb2 u_arb (
      .clk     (clk),
      .nReset  (nReset),
      .req     (req_idle),
      .advance (advance),
      .gnt     (gnt)
   );

   // Select lines depend on q in the same cycle so the chain never steps
   // past its terminal value; nCryOut is only ever used for the sticky check.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      val_d    = val_q;
      up_d     = up_q;
      mode     = HOLD;
      ncry_in  = 1'b1;
      advance  = 1'b0;
      terminal = up_q ? (&q) : (q == '0);

      unique case (state_q)
         ST_IDLE: begin
            if (gnt != 2'b00) begin
               owner_d = gnt[1];
               val_d   = gnt[1] ? valB : valA;
               up_d    = gnt[1] ? upB  : upA;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            mode    = LOAD;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (stall) begin
               state_d = ST_RUN;
            end else if (terminal) begin
               state_d = ST_DONE;
            end else begin
               mode    = up_q ? INC : DEC;
               ncry_in = 1'b0;
            end
         end
         ST_DONE: begin
            advance = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      done_d = '0;
      if ((state_q == ST_RUN) && (state_d == ST_DONE)) begin
         done_d[owner_q] = 1'b1;
      end
      busy_d = (state_d != ST_IDLE);
      err_d  = err_q
             | ((state_q == ST_LOAD) && nCryOut)
             | ((state_q == ST_RUN) && !ncry_in && !nCryOut);
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b0;
         val_q   <= '0;
         up_q    <= 1'b0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         val_q   <= val_d;
         up_q    <= up_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign gntA     = gnt[0];
   assign gntB     = gnt[1];
   assign doneA    = done_q[0];
   assign doneB    = done_q[1];
   assign busy     = busy_q;
   assign sel2     = mode[1];
   assign sel1     = mode[0];
   assign nCryIn   = ncry_in;
   assign d        = val_q;
   assign chainErr = err_q;

endmodule

// File: tb/tb_cnt_seq.sv
// Bench for cnt_seq: a rippled model of the counter slices closes the loop,
// and each operation is predicted from its start value, direction and stalls.
module tb_cnt_seq;

   localparam int unsigned NSLICES = 3;
   localparam int unsigned W = 4 * NSLICES;
   localparam logic [W-1:0] ALL1 = '1;

   logic         clk = 1'b0;
   logic         nReset;
   logic         reqA, reqB, upA, upB, stall, abort;
   logic [W-1:0] valA, valB;
   logic         gntA, gntB, doneA, doneB, busy, sel2, sel1, nCryIn, chainErr;
   logic [W-1:0] d, q;
   logic         nCryOut;

   logic [W-1:0] chain_q = '0;
   logic [W-1:0] chain_nxt;
   logic         nco_model;
   logic         force_nco = 1'b0;

   int cmp_n  = 0;
   int fail_n = 0;
   bit model_prio = 1'b0;   // 0: A preferred

   always #5 clk = ~clk;

   cnt_seq #(.NSLICES(NSLICES)) dut (
      .clk(clk), .nReset(nReset),
      .reqA(reqA), .reqB(reqB), .valA(valA), .valB(valB), .upA(upA), .upB(upB),
      .gntA(gntA), .gntB(gntB), .doneA(doneA), .doneB(doneB),
      .stall(stall), .abort(abort), .busy(busy),
      .sel2(sel2), .sel1(sel1), .nCryIn(nCryIn), .d(d), .q(q),
      .nCryOut(nCryOut), .chainErr(chainErr)
   );

   // Counter slices: LOAD forces carry-out low, HOLD drives it high,
   // INC/DEC step only with an active carry-in and ripple at F / 0.
   always_comb begin : chain_next
      logic [3:0] s, nx;
      logic       c, co;
      chain_nxt = chain_q;
      c = nCryIn;
      for (int unsigned i = 0; i < NSLICES; i++) begin
         s  = chain_q[4*i +: 4];
         nx = s;
         co = 1'b1;
         case ({sel2, sel1})
            2'b00: begin nx = d[4*i +: 4]; co = 1'b0; end
            2'b10: if (!c) begin nx = s + 4'd1; co = (s != 4'hF); end
            2'b01: if (!c) begin nx = s - 4'd1; co = (s != 4'h0); end
            default: ;
         endcase
         chain_nxt[4*i +: 4] = nx;
         c = co;
      end
      nco_model = c;
   end

   always_ff @(posedge clk) chain_q <= chain_nxt;
   assign q       = chain_q;
   assign nCryOut = force_nco ? 1'b1 : nco_model;

   function automatic logic [7:0] obs_vec();
      return {sel2, sel1, nCryIn, gntA, gntB, doneA, doneB, busy};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Serves the requester the arbiter should pick; reqs/vals are set by the caller.
   task automatic serve_one(input int stall_start, input int stall_len, input int abort_at);
      bit win, u;
      logic [W-1:0] v;
      logic [7:0] exp;
      int n, steps;
      win = (reqA && reqB) ? model_prio : reqB;
      v = win ? valB : valA;
      u = win ? upB : upA;
      n = u ? int'(ALL1 - v) : int'(v);
      steps = 0;
      #1;
      exp = {2'b11, 1'b1, !win, win, 3'b000};
      cmp_n++;
      if (obs_vec() !== exp) begin
         fail_n++; $display("FAIL grant: got %b want %b", obs_vec(), exp);
      end
      tick();
      if (win) reqB = 1'b0; else reqA = 1'b0;
      valA = W'($urandom); valB = W'($urandom);
      stall = 1'b0; abort = (abort_at == 1);
      #1;
      exp = {2'b00, 1'b1, 4'b0000, 1'b1};
      cmp_n++;
      if (obs_vec() !== exp) begin
         fail_n++; $display("FAIL load: got %b want %b", obs_vec(), exp);
      end
      cmp_n++;
      if (d !== v) begin
         fail_n++; $display("FAIL load_d: got %h want %h", d, v);
      end
      tick();
      abort = 1'b0;
      for (int c = 2; c < 120; c++) begin
         stall = (c >= stall_start) && (c < stall_start + stall_len);
         abort = (c == abort_at);
         #1;
         if (abort) begin
            exp = {2'b11, 1'b1, 4'b0000, 1'b1};
            cmp_n++;
            if (obs_vec() !== exp) begin
               fail_n++; $display("FAIL abort c%0d: got %b want %b", c, obs_vec(), exp);
            end
            tick();
            abort = 1'b0; stall = 1'b0;
            #1;
            cmp_n++;
            if ({doneA, doneB, busy} !== 3'b000) begin
               fail_n++; $display("FAIL abort_idle: got done/busy %b want 000", {doneA, doneB, busy});
            end
            return;
         end
         if (stall) begin
            exp = {2'b11, 1'b1, 4'b0000, 1'b1};
         end else if (steps < n) begin
            exp = {(u ? 2'b10 : 2'b01), 1'b0, 4'b0000, 1'b1};
            steps++;
         end else begin
            exp = {2'b11, 1'b1, 4'b0000, 1'b1};
            cmp_n++;
            if (obs_vec() !== exp) begin
               fail_n++; $display("FAIL terminal c%0d: got %b want %b", c, obs_vec(), exp);
            end
            tick();
            stall = 1'b0;
            #1;
            exp = {2'b11, 1'b1, 2'b00, !win, win, 1'b1};
            cmp_n++;
            if (obs_vec() !== exp) begin
               fail_n++; $display("FAIL done c%0d: got %b want %b", c + 1, obs_vec(), exp);
            end
            model_prio = !win;
            cmp_n++;
            if (q !== (u ? ALL1 : '0)) begin
               fail_n++; $display("FAIL final_q: got %h want %h", q, (u ? ALL1 : '0));
            end
            tick();
            #1;
            cmp_n++;
            if ({doneA, doneB, busy, d} !== {3'b000, v}) begin
               fail_n++; $display("FAIL after_done: got %b/%h want 000/%h", {doneA, doneB, busy}, d, v);
            end
            return;
         end
         cmp_n++;
         if (obs_vec() !== exp) begin
            fail_n++; $display("FAIL run c%0d: got %b want %b", c, obs_vec(), exp);
         end
         tick();
      end
      fail_n++;
      $display("FAIL op_timeout: got no done within 120 cycles want done by cycle %0d", n + 3);
   endtask

   task automatic test_reset();
      logic [W-1:0] qs;
      nReset = 1'b0;
      #3;
      cmp_n++;
      if ({obs_vec(), d, chainErr} !== {8'b11100000, {W{1'b0}}, 1'b0}) begin
         fail_n++; $display("FAIL reset_outs: got %b/%h/%b want 11100000/0/0", obs_vec(), d, chainErr);
      end
      @(negedge clk) nReset = 1'b1;
      tick();
      reqA = 1'b1; valA = 12'd10; upA = 1'b0;
      tick();
      reqA = 1'b0;
      tick();
      tick();
      #2;
      nReset = 1'b0;
      #1;
      cmp_n++;
      if ({obs_vec(), d, chainErr} !== {8'b11100000, {W{1'b0}}, 1'b0}) begin
         fail_n++; $display("FAIL reset_mid_run: got %b/%h/%b want 11100000/0/0", obs_vec(), d, chainErr);
      end
      qs = q;
      tick();
      cmp_n++;
      if ({q, obs_vec()} !== {qs, 8'b11100000}) begin
         fail_n++; $display("FAIL reset_hold: got q=%h %b want q=%h 11100000", q, obs_vec(), qs);
      end
      @(negedge clk) nReset = 1'b1;
      model_prio = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      reqA = 1'b1; reqB = 1'b1;
      valA = 12'd5; upA = 1'b0; valB = 12'hFFD; upB = 1'b1;
      serve_one(0, 0, -1);
      valB = 12'hFFD; upB = 1'b1;
      serve_one(0, 0, -1);
   endtask

   task automatic test_dec5();
      reqA = 1'b1; valA = 12'd5; upA = 1'b0;
      serve_one(0, 0, -1);
   endtask

   task automatic test_zero();
      reqA = 1'b1; valA = '0; upA = 1'b0;
      serve_one(0, 0, 1);
   endtask

   task automatic test_stall_abort();
      reqA = 1'b1; valA = 12'd4; upA = 1'b0;
      serve_one(4, 2, -1);
      reqB = 1'b1; valB = 12'd8; upB = 1'b0;
      serve_one(0, 0, 4);
      reqA = 1'b1; reqB = 1'b1;
      valA = 12'd3; upA = 1'b0; valB = 12'hFFC; upB = 1'b1;
      serve_one(0, 0, -1);
      valA = 12'd3; upA = 1'b0;
      serve_one(0, 0, -1);
   endtask

   task automatic test_random();
      int na, nb, ab;
      for (int k = 0; k < 14; k++) begin
         reqA = reqA | 1'($urandom_range(0, 1));
         reqB = reqB | 1'($urandom_range(0, 1));
         if (!reqA && !reqB) reqA = 1'b1;
         na = $urandom_range(0, 15); nb = $urandom_range(0, 15);
         upA = 1'($urandom_range(0, 1)); upB = 1'($urandom_range(0, 1));
         valA = upA ? ALL1 - W'(na) : W'(na);
         valB = upB ? ALL1 - W'(nb) : W'(nb);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : -1;
         serve_one($urandom_range(2, 10), $urandom_range(0, 3), ab);
      end
      reqA = 1'b0; reqB = 1'b0;
      tick();
      cmp_n++;
      if (chainErr !== 1'b0) begin
         fail_n++; $display("FAIL err_clean: got %b want 0", chainErr);
      end
   endtask

   task automatic test_chain_err();
      reqA = 1'b1; valA = 12'd3; upA = 1'b0;
      #1;
      tick();
      reqA = 1'b0;
      force_nco = 1'b1;
      #1;
      cmp_n++;
      if (chainErr !== 1'b0) begin
         fail_n++; $display("FAIL err_before: got %b want 0", chainErr);
      end
      tick();
      force_nco = 1'b0;
      #1;
      cmp_n++;
      if (chainErr !== 1'b1) begin
         fail_n++; $display("FAIL err_set: got %b want 1", chainErr);
      end
      repeat (10) tick();
      cmp_n++;
      if (chainErr !== 1'b1) begin
         fail_n++; $display("FAIL err_sticky: got %b want 1", chainErr);
      end
      nReset = 1'b0;
      #1;
      cmp_n++;
      if (chainErr !== 1'b0) begin
         fail_n++; $display("FAIL err_reset: got %b want 0", chainErr);
      end
      @(negedge clk) nReset = 1'b1;
      model_prio = 1'b0;
      tick();
   endtask

   initial begin
      #400000;
      fail_n++;
      $display("FAIL watchdog: got time limit reached want $finish earlier");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reqA = 1'b0; reqB = 1'b0; upA = 1'b0; upB = 1'b0;
      valA = '0; valB = '0; stall = 1'b0; abort = 1'b0;
      test_reset();
      test_back_to_back();
      test_dec5();
      test_zero();
      test_stall_abort();
      test_random();
      test_chain_err();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
      $finish;
   end

endmodule

// File: doc/cnt_seq.md
# cnt_seq

Sequencer and two-requester arbiter for a cascaded chain of 4-bit universal counter slices (10136-style: LOAD/DEC/INC/HOLD select, active-low ripple carry). It grants the counter chain to one of two requesters and loads that requester's start value. It then steps the chain up or down to its terminal count and pulses a per-requester done. It owns the chain's shared select lines and the least-significant carry-in, and cross-checks the chain's most-significant carry-out.

## Interface
Parameters:
- NSLICES, 3, number of cascaded 4-bit slices; W = 4*NSLICES.

Ports:
- clk  in  1  sole clock, rising edge.
- nReset  in  1  reset; asynchronous assert, active-low.
- reqA, reqB  in  1  request, held until granted.
- valA, valB  in  W  start value, sampled in the grant cycle.
- upA, upB  in  1  direction: 1 = INC to all-ones, 0 = DEC to zero.
- gntA, gntB  out  1  one-cycle grant.
- doneA, doneB  out  1  one-cycle completion pulse.
- stall  in  1  freeze counting.
- abort  in  1  abandon the current operation.
- busy  out  1  state != IDLE.
- sel2, sel1  out  1  chain mode, shared by all slices: 00 LOAD, 01 DEC, 10 INC, 11 HOLD.
- nCryIn  out  1  carry/borrow into slice 0, active-low.
- d  out  W  load data to the chain.
- q  in  W  chain value.
- nCryOut  in  1  carry-out of the top slice.
- chainErr  out  1  sticky carry-chain check failure.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - {sel2,sel1} = HOLD and nCryIn = 1.
  - If any request is present, grant one (combinational gnt in the same cycle) and latch its owner, value and direction. Next state is LOAD.
- LOAD: sel = LOAD and d = latched value. Next state is RUN.
- RUN, first matching rule applies:
  - abort: sel = HOLD, go to IDLE, no done.
  - stall: sel = HOLD, stay in RUN.
  - Terminal (q == 0 when DEC, q == all-ones when INC): sel = HOLD, go to DONE.
  - Otherwise: sel = DEC or INC, nCryIn = 0.
- DONE:
  - sel = HOLD.
  - Pulse done for the owner.
  - Point the round-robin priority at the other requester.
  - Go to IDLE.
- Terminal detection uses q only; nCryOut never feeds sel or nCryIn, so there is no combinational loop.
- Arbitration:
  - Round-robin; after reset, A has priority.
  - A lone requester always wins.
  - Requests arriving while busy wait.
  - Priority changes only on DONE; an abort leaves it unchanged.
- d holds the latched value from the grant until the next grant.
- chainErr sets when either of these is seen at a clock edge:
  - LOAD with nCryOut = 1 (a load must force carry-out).
  - RUN counting (nCryIn = 0) with nCryOut = 0 (terminal reached while stepping).
- chainErr stays set until reset.
- Wrap-around never occurs: the chain is never stepped from its terminal value.

## Timing
- Grant at cycle 0, LOAD at cycle 1, RUN starts at cycle 2.
- Start value N with DEC (or all-ones − N with INC) gives N stepping cycles, one terminal-detect cycle, then done at cycle N+3.
- N = 0 gives done at cycle 3.
- Each stall cycle adds one cycle.
- Back-to-back: a new grant may occur in the IDLE cycle right after DONE, so successive operations are at least N+4 cycles apart.
- Reset values: state IDLE, sel = 11, nCryIn = 1, d = 0, gnt = 0, done = 0, busy = 0, chainErr = 0, priority = A.
- Reset mid-operation returns to IDLE with no done pulse; the chain contents are left untouched.
- Simultaneous events:
  - abort beats stall, and stall beats terminal.
  - abort in LOAD is ignored; it is honoured in RUN.

## Structure
- The shared package mc10k_pkg holds:
  - tCounterMode {LOAD, DEC, INC, HOLD}, encoded 00/01/10/11 to match the slice select pins.
  - tSeqState.
- The round-robin pick and priority register form one sub-module, rr_arb2 (req[1:0], advance → gnt[1:0]).
- A bench model of the chain is NSLICES counter slices with their carries rippled.

## Test plan
- Reset mid-RUN: the outputs match the reset values above.
- reqA with valA = 5, upA = 0:
  - gntA at cycle 0, sel = 00 at cycle 1.
  - DEC for cycles 2–6, HOLD at cycle 7.
  - doneA at cycle 8; final q = 0.
- reqA and reqB together with valB = 0xFFD, upB = 1:
  - A is served first, then B is granted in the IDLE after A's DONE.
  - B steps 2 cycles; doneB arrives 5 cycles after gntB with q = 0xFFF.
- valA = 0: HOLD throughout RUN, doneA 3 cycles after the grant, q = 0.
- valA = 4, stall high for 2 cycles during RUN: done at cycle 9. Then abort during a second run: no done, busy drops the next cycle, and the next grant still favours the requester that had priority before the abort.
- Force nCryOut = 1 during LOAD: chainErr rises after that edge and stays high until nReset.
